// File: rtl/axi_timer_pkg.sv
// Shared types for the axi_timer register block and its bus master.
// Holds the master FSM state encoding and the timer register map.
package axi_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_RSP
  } state_t;

  localparam int unsigned REG_CR      = 0;
  localparam int unsigned REG_SR      = 1;
  localparam int unsigned REG_PERIOD  = 2;
  localparam int unsigned REG_COUNTER = 3;
  localparam int unsigned REG_IRQ_CNT = 4;

endpackage

// File: rtl/axi_bus.sv
// Simple register bus: address phase, then a write or read data phase.
// Master drives valids/addr/wdata/rready; slave answers with readys/rdata.
interface axi_bus #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
);
  logic              avalid;
  logic              awrite;
  logic [ADDR_W-1:0] addr;
  logic              aready;
  logic              wvalid;
  logic [DATA_W-1:0] wdata;
  logic              wready;
  logic              rready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport Master (
    output avalid, awrite, addr,
    output wvalid, wdata, rready,
    input  aready, wready, rvalid, rdata
  );

  modport Slave (
    input  avalid, awrite, addr,
    input  wvalid, wdata, rready,
    output aready, wready, rvalid, rdata
  );
endinterface

// File: rtl/axi_reg_master.sv
// Single-outstanding command-to-bus register master with per-phase timeout.
// Ports: i_clk, i_rst (sync, high), cmd valid/ready/write/addr/wdata, rsp valid/ready/rdata/err, axi_master.
module axi_reg_master
  import axi_timer_pkg::*;
#(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  axi_bus.Master            axi_master
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = cnt_t'(TIMEOUT);

  state_t            state_q, state_n;
  cnt_t              cnt_q, cnt_n;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q, rdata_n;
  logic              err_q, err_n;
  logic              avalid_q, wvalid_q, rready_q;
  logic              rsp_valid_q, cmd_ready_q;
  logic              accept;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    rdata_n = rdata_q;
    err_n   = err_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_ready_q && i_cmd_valid) begin
          accept  = 1'b1;
          state_n = ST_ADDR;
          cnt_n   = '0;
        end
      end
      ST_ADDR: begin
        if (axi_master.aready) begin
          state_n = wr_q ? ST_WDATA : ST_RDATA;
          cnt_n   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_n = ST_RSP;
          err_n   = 1'b1;
          rdata_n = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      ST_WDATA: begin
        if (axi_master.wready) begin
          state_n = ST_RSP;
          err_n   = 1'b0;
          rdata_n = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_n = ST_RSP;
          err_n   = 1'b1;
          rdata_n = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      ST_RDATA: begin
        if (axi_master.rvalid) begin
          state_n = ST_RSP;
          err_n   = 1'b0;
          rdata_n = axi_master.rdata;
        end else if (cnt_q == CNT_MAX) begin
          state_n = ST_RSP;
          err_n   = 1'b1;
          rdata_n = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      ST_RSP: begin
        // Clear the response payload on exit so idle outputs read as zero.
        if (i_rsp_ready) begin
          state_n = ST_IDLE;
          err_n   = 1'b0;
          rdata_n = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Phase strobes are registered from the next state so each one is
  // high exactly while the FSM sits in its own state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      avalid_q    <= 1'b0;
      wvalid_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      rdata_q     <= rdata_n;
      err_q       <= err_n;
      avalid_q    <= (state_n == ST_ADDR);
      wvalid_q    <= (state_n == ST_WDATA);
      rready_q    <= (state_n == ST_RDATA);
      rsp_valid_q <= (state_n == ST_RSP);
      cmd_ready_q <= (state_n == ST_IDLE);
      if (accept) begin
        wr_q    <= i_cmd_write;
        addr_q  <= i_cmd_addr;
        wdata_q <= i_cmd_wdata;
      end
    end
  end

  assign o_cmd_ready       = cmd_ready_q;
  assign o_rsp_valid       = rsp_valid_q;
  assign o_rsp_rdata       = rdata_q;
  assign o_rsp_err         = err_q;
  assign axi_master.avalid = avalid_q;
  assign axi_master.awrite = wr_q;
  assign axi_master.addr   = addr_q;
  assign axi_master.wvalid = wvalid_q;
  assign axi_master.wdata  = wdata_q;
  assign axi_master.rready = rready_q;

endmodule

// File: tb/tb_axi_reg_master.sv
// Randomized bench for axi_reg_master against a delay-programmable slave.
// A transaction-level model predicts error, data, latency and phase lengths.
module tb_axi_reg_master;

  localparam int AW = 3;
  localparam int DW = 32;
  localparam int TO = 7;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  axi_bus #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axi_reg_master #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .i_cmd_write(cmd_write),
    .i_cmd_addr (cmd_addr),
    .i_cmd_wdata(cmd_wdata),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata),
    .o_rsp_err  (rsp_err),
    .axi_master (bus.Master)
  );

  always #5 clk = ~clk;

  // Slave: ready/valid after a programmed number of wait cycles.
  int            a_dly;
  int            d_dly;
  int            acnt;
  int            dcnt;
  logic          s_clr;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] sregs [8];

  assign bus.aready = bus.avalid && (acnt == a_dly);
  assign bus.wready = bus.wvalid && (dcnt == d_dly);
  assign bus.rvalid = bus.rready && (dcnt == d_dly);
  assign bus.rdata  = bus.rvalid ? sregs[s_addr] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (bus.avalid && !bus.aready) acnt <= acnt + 1;
    else acnt <= 0;
    if ((bus.wvalid && !bus.wready) || (bus.rready && !bus.rvalid))
      dcnt <= dcnt + 1;
    else
      dcnt <= 0;
    if (bus.avalid && bus.aready) s_addr <= bus.addr;
    if (s_clr) begin
      for (int i = 0; i < 8; i++) sregs[i] <= '0;
    end else if (bus.wvalid && bus.wready) begin
      sregs[s_addr] <= bus.wdata;
    end
  end

  int          n_pass = 0;
  int          n_chk  = 0;
  logic [31:0] mregs [8];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic do_txn(input bit w, input int a, input logic [31:0] d,
                        input int da, input int dd, input int hold);
    bit          a_ok, d_ok, err;
    int          lat, exp_lat, av, wv, rr, bad;
    logic [31:0] exp_rd, r0;
    logic        e0;
    a_ok    = (da <= TO);
    d_ok    = a_ok && (dd <= TO);
    err     = !(a_ok && d_ok);
    exp_lat = 1 + mn(da, TO) + 1;
    if (a_ok) exp_lat += mn(dd, TO) + 1;
    exp_rd  = (!err && !w) ? mregs[a] : 32'h0;
    if (!err && w) mregs[a] = d;

    a_dly = da;
    d_dly = dd;
    chk("cmd_ready_idle", {31'b0, cmd_ready}, 1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = AW'(a);
    cmd_wdata = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    lat = 1; av = 0; wv = 0; rr = 0; bad = 0;
    while (1) begin
      if (bus.avalid) begin
        av++;
        if (bus.addr !== AW'(a) || bus.awrite !== w) bad++;
      end
      if (bus.wvalid) begin
        wv++;
        if (bus.wdata !== d) bad++;
      end
      if (bus.rready) rr++;
      if (rsp_valid || lat > 4 * TO + 20) break;
      if (cmd_ready) bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("rsp_seen", {31'b0, rsp_valid}, 1);
    chk("latency", lat, exp_lat);
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, err});
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("avalid_cycles", av, mn(da, TO) + 1);
    chk("wvalid_cycles", wv, (a_ok && w) ? mn(dd, TO) + 1 : 0);
    chk("rready_cycles", rr, (a_ok && !w) ? mn(dd, TO) + 1 : 0);
    chk("phase_stable", bad, 0);
    chk("strobes_low_rsp",
        {29'b0, bus.avalid, bus.wvalid, bus.rready}, 0);

    r0 = rsp_rdata; e0 = rsp_err; bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== r0 ||
          rsp_err !== e0 || cmd_ready !== 1'b0) bad++;
    end
    chk("rsp_hold", bad, 0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("rsp_done", {30'b0, rsp_valid, cmd_ready}, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst     = 1'b1;
    s_clr     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    a_dly     = 0;
    d_dly     = 0;
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 0);
    chk("rst_rsp", {30'b0, rsp_valid, rsp_err}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_strobes",
        {28'b0, bus.avalid, bus.wvalid, bus.rready, bus.awrite}, 0);
    chk("rst_addr", {29'b0, bus.addr}, 0);
    chk("rst_wdata", bus.wdata, 0);
    i_rst = 1'b0;
    s_clr = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", {31'b0, cmd_ready}, 1);

    do_txn(1, 2, 32'h0000_1000, 0, 0, 0);
    do_txn(0, 2, 32'h0, 0, 0, 0);
    do_txn(1, 0, 32'h0000_0001, 0, 0, 0);
    do_txn(0, 0, 32'h0, 0, 0, 0);
    do_txn(1, 1, 32'h1234_5678, TO + 3, 0, 0);
    do_txn(0, 0, 32'h0, 1, 2, 10);
    do_txn(0, 2, 32'h0, 0, TO, 1);
    do_txn(1, 4, 32'hCAFE_0004, TO, TO, 2);
    do_txn(0, 4, 32'h0, 2, TO + 1, 3);
    do_txn(1, 3, 32'h0000_0055, 0, 0, 0);

    // Reset in the middle of a stalled write data phase.
    a_dly     = 0;
    d_dly     = TO + 5;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 3'd3;
    cmd_wdata = 32'h0000_00AA;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 10 && !bus.wvalid; i++) begin
      @(posedge clk);
      #1;
    end
    chk("rst_mid_wvalid_seen", {31'b0, bus.wvalid}, 1);
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_strobes",
        {29'b0, bus.wvalid, bus.avalid, rsp_valid}, 0);
    chk("rst_mid_cmd_ready", {31'b0, cmd_ready}, 0);
    i_rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_idle", {30'b0, cmd_ready, rsp_valid}, 32'h2);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_no_rsp", {31'b0, rsp_valid}, 0);
    do_txn(0, 3, 32'h0, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      do_txn($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
             $urandom_range(0, TO + 2), $urandom_range(0, TO + 2),
             $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
